mc_main_control: RTL and testbench
==================================

Name: mc_main_control

Overview:
- Multicycle MIPS main control unit. Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives ALU_Control into the 32-bit ALU, plus every mux select and write strobe for PC, IR, memory and register file.
- Sits between the instruction register (opcode/funct) and the datapath. It is the producer side of the ALU_Control interface.

Parameters:
- STATE_W, 4, state register width; state encodings listed below must fit.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; datapath holds it stable from DECODE until the instruction retires.
- funct  in  6  IR[5:0]; same stability as opcode.
- zero  in  1  ALU zero flag.
- ALU_Control  out  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- ALUSrcA  out  1  0=PC, 1=regA.
- ALUSrcB  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- IorD  out  1  memory address: 0=PC, 1=ALUOut.
- MemRead, MemWrite, IRWrite, RegWrite  out  1 each  write/read strobes.
- MemtoReg  out  1  register-file write data: 1=MDR, 0=ALUOut.
- RegDst  out  1  register-file write address: 1=rd, 0=rt.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- pc_en  out  1  PCWrite OR (PCWriteCond AND zero).
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- instr_count  out  CNT_W  retired-instruction count.
- state  out  STATE_W  current state, for debug.

Behaviour:
- States: IDLE=15, FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, HALT=12 (HALT only with the optional feature).
- Reset: async assert forces IDLE from any state, including mid-instruction; instr_count is cleared to 0.
- IDLE outputs: all strobes 0, pc_en 0, selects 0, ALU_Control=0010. IDLE always moves to FETCH on the next clock.
- Default rule: any output not listed for a state is 0; ALU_Control defaults to ADD.
- FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSource=00, pc_en=1. Next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut). Dispatch on opcode:
  - 0x00 -> EXEC
  - 0x23 lw or 0x2B sw -> MEM_ADDR
  - 0x04 beq -> BRANCH
  - 0x02 j -> JUMP
  - 0x08 addi -> ADDI_EX
  - any other opcode -> illegal handling
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ADD. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1. Next state MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Retires.
- MEM_WR: MemWrite=1, IorD=1. Retires.
- EXEC: ALUSrcA=1, ALUSrcB=00. funct decode: 0x20->0010, 0x22->0110, 0x24->0000, 0x25->0001, 0x2A->0111, 0x27->1100. Any other funct -> illegal handling. Otherwise next state R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Retires.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, pc_en=zero. Retires.
- JUMP: PCSource=10, pc_en=1. Retires.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ADD. Next state ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Retires.
- Retire: instr_done=1 for exactly that cycle; instr_count increments on the closing clock edge; next state FETCH.
- instr_count wraps from all-ones to 0 with no flag.
- CPI: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- No state ever asserts MemRead and MemWrite together, or RegWrite and MemWrite together.
- Illegal opcode or funct (feature absent): no strobe asserted in the detecting state. The instruction is treated as a NOP: instr_done pulses, instr_count increments, next state FETCH.

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined:
  - Illegal opcode or funct enters HALT on the next clock instead of retiring.
  - HALT drives all strobes 0 and pc_en 0, does not pulse instr_done, and does not increment instr_count.
  - HALT is left only by reset.
  - Extra output port illegal (1 bit) is 1 in HALT, else 0; reset value 0.
- Undefined: NOP behaviour as above; no illegal port and no HALT state.

Test Plan:
- Reset then release, opcode=0x00, funct=0x20 -> IDLE, FETCH, DECODE, EXEC (ALU_Control=0010), R_WB (RegWrite=1, RegDst=1); instr_done at cycle 5 after release; instr_count=1.
- opcode=0x23 -> states 0,1,2,3,4; MEM_RD has MemRead=1, IorD=1; MEM_WB has MemtoReg=1. Repeat with opcode=0x2B -> states 0,1,2,5 with MemWrite=1 only in state 5.
- opcode=0x04: zero=1 -> pc_en=1, PCSource=01, ALU_Control=0110 in BRANCH; zero=0 -> pc_en=0 in BRANCH.
- Sweep funct 0x24/0x25/0x2A/0x27/0x22 -> EXEC ALU_Control 0000/0001/0111/1100/0110. funct=0x3F -> no RegWrite, back to FETCH (feature off), or HALT with illegal=1 (feature on).
- Assert rst_n low during MEM_RD -> state=15 and all strobes 0 immediately, without waiting for a clock edge; instr_count=0; FETCH one clock after release.
- Preload instr_count to all-ones via retirements with CNT_W=4 (16 j instructions) -> count wraps to 0; opcode=0x02 gives PCSource=10, pc_en=1 in JUMP.

Source files
------------

// File: rtl/mc_main_control.sv
// mc_main_control: multicycle MIPS main control FSM; define MC_ILLEGAL_TRAP_EN to trap illegal instructions in HALT
module mc_main_control #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic [3:0]         ALU_Control,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic               pc_en,
  output logic               instr_done,
  output logic [CNT_W-1:0]   instr_count,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic               illegal,
`endif
  output logic [STATE_W-1:0] state
);
  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEM_ADDR = STATE_W'(2),
    MEM_RD   = STATE_W'(3),
    MEM_WB   = STATE_W'(4),
    MEM_WR   = STATE_W'(5),
    EXEC     = STATE_W'(6),
    R_WB     = STATE_W'(7),
    BRANCH   = STATE_W'(8),
    JUMP     = STATE_W'(9),
    ADDI_EX  = STATE_W'(10),
    ADDI_WB  = STATE_W'(11),
`ifdef MC_ILLEGAL_TRAP_EN
    HALT     = STATE_W'(12),
`endif
    IDLE     = STATE_W'(15)
  } state_t;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_t ILL_NXT    = HALT;
  localparam logic   RETIRE_ILL = 1'b0;
`else
  localparam state_t ILL_NXT    = FETCH;
  localparam logic   RETIRE_ILL = 1'b1;
`endif
  state_t     cur, nxt;
  logic       is_lw, is_sw, legal_op, legal_fn;
  logic [3:0] fn_alu;
  assign is_lw    = opcode == 6'h23;
  assign is_sw    = opcode == 6'h2B;
  assign legal_op = opcode inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
  assign legal_fn = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
  assign fn_alu   = funct == 6'h22 ? ALU_SUB :
                    funct == 6'h24 ? ALU_AND :
                    funct == 6'h25 ? ALU_OR  :
                    funct == 6'h2A ? ALU_SLT :
                    funct == 6'h27 ? ALU_NOR : ALU_ADD;
  always_comb begin
    nxt         = IDLE;
    ALU_Control = ALU_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    pc_en       = 1'b0;
    instr_done  = 1'b0;
    case (cur)
      IDLE:     nxt = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        pc_en   = 1'b1;
        nxt     = DECODE;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        nxt        = opcode == 6'h00   ? EXEC     :
                     (is_lw || is_sw)  ? MEM_ADDR :
                     opcode == 6'h04   ? BRANCH   :
                     opcode == 6'h02   ? JUMP     :
                     opcode == 6'h08   ? ADDI_EX  : ILL_NXT;
        instr_done = !legal_op && RETIRE_ILL;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = is_lw ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        nxt     = MEM_WB;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      EXEC: begin
        ALUSrcA     = 1'b1;
        ALU_Control = fn_alu;
        nxt         = legal_fn ? R_WB : ILL_NXT;
        instr_done  = !legal_fn && RETIRE_ILL;
      end
      R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_Control = ALU_SUB;
        PCSource    = 2'b01;
        pc_en       = zero;
        instr_done  = 1'b1;
        nxt         = FETCH;
      end
      JUMP: begin
        PCSource   = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      HALT:     nxt = HALT;
`endif
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= IDLE;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (instr_done) instr_count <= instr_count + CNT_W'(1);
    end
  end
  assign state = cur;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal = cur == HALT;
`endif
endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: scoreboard bench for mc_main_control with per-cycle expected control words
module tb_mc_main_control;
  logic        clk, rst_n, zero, fin;
  logic [5:0]  opcode, funct;
  logic [3:0]  ALU_Control, state, instr_count;
  logic        ALUSrcA, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst, pc_en, instr_done;
  logic [1:0]  ALUSrcB, PCSource;
`ifdef MC_ILLEGAL_TRAP_EN
  logic        illegal;
`endif
  mc_main_control #(.STATE_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .ALU_Control(ALU_Control), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .PCSource(PCSource), .pc_en(pc_en),
    .instr_done(instr_done), .instr_count(instr_count),
`ifdef MC_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .state(state)
  );
  localparam logic [3:0] S_FETCH = 0, S_DEC = 1, S_MADDR = 2, S_MRD = 3, S_MWB = 4, S_MWR = 5,
                         S_EXEC = 6, S_RWB = 7, S_BR = 8, S_J = 9, S_AEX = 10, S_AWB = 11,
                         S_HALT = 12, S_IDLE = 15;
  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110;
  // word layout: alu, srcA, srcB, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst, PCSource, pc_en
  localparam logic [16:0] C_IDLE  = {ADD, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
  localparam logic [16:0] C_FETCH = {ADD, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
  localparam logic [16:0] C_DEC   = {ADD, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
  localparam logic [16:0] C_MADDR = {ADD, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
  localparam logic [16:0] C_MRD   = {ADD, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
  localparam logic [16:0] C_MWB   = {ADD, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
  localparam logic [16:0] C_MWR   = {ADD, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
  localparam logic [16:0] C_RWB   = {ADD, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0};
  localparam logic [16:0] C_AWB   = {ADD, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
  localparam logic [16:0] C_JUMP  = {ADD, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1};
  typedef struct {
    string       nm;
    logic [3:0]  st;
    logic [16:0] c;
    logic        d;
    logic [3:0]  n;
  } rec_t;
  rec_t        q[$];
  rec_t        r;
  logic [3:0]  exp_cnt;
  logic [16:0] act;
  int          vectors = 0, miscompares = 0;
  assign act = {ALU_Control, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
                RegWrite, MemtoReg, RegDst, PCSource, pc_en};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end
  initial begin
    forever begin
      @(negedge clk or negedge rst_n or posedge fin);
      #1;
      if (fin) begin
        vectors++;
        if (q.size() != 0) begin
          miscompares++;
          $display("FAIL drain: %0d records left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end else if (q.size() != 0) begin
        r = q.pop_front();
        vectors++;
        if (state !== r.st || act !== r.c || instr_done !== r.d || instr_count !== r.n) begin
          miscompares++;
          $display("FAIL %s: got state=%0d ctl=%b done=%b cnt=%0d, expected state=%0d ctl=%b done=%b cnt=%0d",
                   r.nm, state, act, instr_done, instr_count, r.st, r.c, r.d, r.n);
        end
      end
    end
  end
  task automatic cyc(input string nm, input logic [3:0] st, input logic [16:0] c, input logic d);
    @(posedge clk);
    #1;
    q.push_back('{nm, st, c, d, exp_cnt});
    if (d) exp_cnt = exp_cnt + 4'd1;
  endtask
  task automatic reset_seq();
    #6;
    q.push_back('{"RESET", S_IDLE, C_IDLE, 1'b0, 4'd0});
    rst_n = 1'b0;
    exp_cnt = 4'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.push_back('{"RELEASE", S_IDLE, C_IDLE, 1'b0, 4'd0});
  endtask
  task automatic rtype(input logic [5:0] f, input logic [3:0] alu);
    cyc("FETCH", S_FETCH, C_FETCH, 1'b0);
    opcode = 6'h00;
    funct  = f;
    cyc("DECODE", S_DEC, C_DEC, 1'b0);
    cyc("EXEC", S_EXEC, {alu, 1'b1, 12'b0}, 1'b0);
    cyc("R_WB", S_RWB, C_RWB, 1'b1);
  endtask
  task automatic ldst(input logic lw);
    cyc("FETCH", S_FETCH, C_FETCH, 1'b0);
    opcode = lw ? 6'h23 : 6'h2B;
    cyc("DECODE", S_DEC, C_DEC, 1'b0);
    cyc("MEM_ADDR", S_MADDR, C_MADDR, 1'b0);
    if (lw) begin
      cyc("MEM_RD", S_MRD, C_MRD, 1'b0);
      cyc("MEM_WB", S_MWB, C_MWB, 1'b1);
    end else begin
      cyc("MEM_WR", S_MWR, C_MWR, 1'b1);
    end
  endtask
  task automatic beq(input logic z);
    cyc("FETCH", S_FETCH, C_FETCH, 1'b0);
    opcode = 6'h04;
    zero   = z;
    cyc("DECODE", S_DEC, C_DEC, 1'b0);
    cyc("BRANCH", S_BR, {SUB, 1'b1, 2'b00, 7'b0, 2'b01, z}, 1'b1);
  endtask
  task automatic addi();
    cyc("FETCH", S_FETCH, C_FETCH, 1'b0);
    opcode = 6'h08;
    cyc("DECODE", S_DEC, C_DEC, 1'b0);
    cyc("ADDI_EX", S_AEX, C_MADDR, 1'b0);
    cyc("ADDI_WB", S_AWB, C_AWB, 1'b1);
  endtask
  task automatic jmp();
    cyc("FETCH", S_FETCH, C_FETCH, 1'b0);
    opcode = 6'h02;
    cyc("DECODE", S_DEC, C_DEC, 1'b0);
    cyc("JUMP", S_J, C_JUMP, 1'b1);
  endtask
  task automatic illegal_fn();
    cyc("FETCH", S_FETCH, C_FETCH, 1'b0);
    opcode = 6'h00;
    funct  = 6'h3F;
    cyc("DECODE", S_DEC, C_DEC, 1'b0);
`ifdef MC_ILLEGAL_TRAP_EN
    cyc("EXEC_ILL", S_EXEC, {ADD, 1'b1, 12'b0}, 1'b0);
    cyc("HALT", S_HALT, C_IDLE, 1'b0);
    cyc("HALT_HOLD", S_HALT, C_IDLE, 1'b0);
    reset_seq();
`else
    cyc("EXEC_ILL", S_EXEC, {ADD, 1'b1, 12'b0}, 1'b1);
`endif
  endtask
  task automatic illegal_op();
    cyc("FETCH", S_FETCH, C_FETCH, 1'b0);
    opcode = 6'h3F;
`ifdef MC_ILLEGAL_TRAP_EN
    cyc("DECODE_ILL", S_DEC, C_DEC, 1'b0);
    cyc("HALT_OP", S_HALT, C_IDLE, 1'b0);
    reset_seq();
`else
    cyc("DECODE_ILL", S_DEC, C_DEC, 1'b1);
`endif
  endtask
  initial begin
    fin     = 1'b0;
    rst_n   = 1'b0;
    opcode  = 6'h00;
    funct   = 6'h00;
    zero    = 1'b0;
    exp_cnt = 4'd0;
    cyc("RESET0", S_IDLE, C_IDLE, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.push_back('{"RELEASE0", S_IDLE, C_IDLE, 1'b0, 4'd0});
    rtype(6'h20, 4'b0010);
    ldst(1'b1);
    ldst(1'b0);
    beq(1'b1);
    beq(1'b0);
    rtype(6'h24, 4'b0000);
    rtype(6'h25, 4'b0001);
    rtype(6'h2A, 4'b0111);
    rtype(6'h27, 4'b1100);
    rtype(6'h22, 4'b0110);
    addi();
    illegal_fn();
    illegal_op();
    cyc("FETCH", S_FETCH, C_FETCH, 1'b0);
    opcode = 6'h23;
    cyc("DECODE", S_DEC, C_DEC, 1'b0);
    cyc("MEM_ADDR", S_MADDR, C_MADDR, 1'b0);
    cyc("MEM_RD", S_MRD, C_MRD, 1'b0);
    reset_seq();
    for (int i = 0; i < 17; i++) jmp();
    repeat (2) @(negedge clk);
    #3;
    fin = 1'b1;
  end
endmodule
